// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: opcode encodings, FSM states and
// the decoded strobe bundle driven towards the datapath.
package seq_pkg;

  // Narrowest legal opcode field; wider fields only extend the illegal range.
  localparam int unsigned OpcodeBits = 3;

  typedef enum logic [OpcodeBits-1:0] {
    OpMov  = 3'd0,
    OpMac  = 3'd1,
    OpWait = 3'd2,
    OpSetr = 3'd3,
    OpLdsw = 3'd4
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StLdswClr
  } state_e;

  typedef struct packed {
    logic f_reg_e;
    logic f_wait;
    logic f_load;
    logic f_clr;
    logic wr_res;
  } ctrl_t;

  localparam ctrl_t CtrlNone    = '0;
  localparam ctrl_t CtrlLdswClr = '{f_reg_e: 1'b0, f_wait: 1'b0, f_load: 1'b0,
                                    f_clr: 1'b1, wr_res: 1'b1};

endpackage

// File: rtl/seq_decode.sv
// Combinational decode of one instruction into its first-cycle strobes,
// register enables, repeat count and illegal flag.
module seq_decode
  import seq_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH  = 3,
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned N_REGS        = 3
) (
  input  logic [OPCODE_WIDTH-1:0]  opcode,
  input  logic [OPERAND_WIDTH-1:0] operand,
  output ctrl_t                    ctrl,
  output logic [N_REGS-1:0]        alu_reg_en,
  output logic [OPERAND_WIDTH-1:0] count,
  output logic                     is_ldsw,
  output logic                     illegal
);

  localparam logic [OPCODE_WIDTH-1:0]  LastOp  = OPCODE_WIDTH'(OpLdsw);
  localparam logic [N_REGS-1:0]        RegOne  = N_REGS'(1);
  localparam logic [OPERAND_WIDTH:0]   RegLim  = (OPERAND_WIDTH+1)'(N_REGS);

  logic    op_undef;
  opcode_e op;

  assign op_undef = opcode > LastOp;
  assign op       = opcode_e'(opcode[OpcodeBits-1:0]);

  always_comb begin
    ctrl       = CtrlNone;
    alu_reg_en = '0;
    count      = '0;
    is_ldsw    = 1'b0;
    illegal    = op_undef;
    if (!op_undef) begin
      case (op)
        OpMov: begin
          ctrl.wr_res = 1'b1;
          ctrl.f_clr  = 1'b1;
          alu_reg_en  = '1;
        end
        OpMac: begin
          ctrl.f_reg_e = 1'b1;
          ctrl.wr_res  = 1'b1;
          count        = operand;
        end
        OpWait: begin
          ctrl.f_wait = 1'b1;
          count       = operand;
        end
        OpSetr: begin
          if ({1'b0, operand} >= RegLim) illegal = 1'b1;
          else                           alu_reg_en = RegOne << operand;
        end
        OpLdsw: begin
          ctrl.f_load  = 1'b1;
          ctrl.f_reg_e = 1'b1;
          alu_reg_en   = '1;
          is_ldsw      = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Valid/ready instruction sequencer: decodes each accepted instruction and
// plays out its registered control strobes over one or more cycles.
module instruction_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH  = 3,
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned N_REGS        = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [OPCODE_WIDTH-1:0]  instr_opcode,
  input  logic [OPERAND_WIDTH-1:0] instr_operand,
  input  logic                     flush,
  output logic                     f_reg_e,
  output logic                     f_wait,
  output logic                     f_load,
  output logic                     f_clr,
  output logic                     wr_res,
  output logic [N_REGS-1:0]        alu_reg_en,
  output logic                     busy,
  output logic                     illegal
);

  state_e                   state_q;
  logic [OPERAND_WIDTH-1:0] cnt_q;
  logic                     ldsw_q;
  ctrl_t                    ctrl_q;
  logic [N_REGS-1:0]        alu_q;
  logic                     busy_q;
  logic                     illegal_q;

  ctrl_t                    dec_ctrl;
  logic [N_REGS-1:0]        dec_alu;
  logic [OPERAND_WIDTH-1:0] dec_count;
  logic                     dec_ldsw;
  logic                     dec_illegal;

  logic last_cycle;
  logic accept;

  seq_decode #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .OPERAND_WIDTH(OPERAND_WIDTH),
    .N_REGS       (N_REGS)
  ) u_decode (
    .opcode    (instr_opcode),
    .operand   (instr_operand),
    .ctrl      (dec_ctrl),
    .alu_reg_en(dec_alu),
    .count     (dec_count),
    .is_ldsw   (dec_ldsw),
    .illegal   (dec_illegal)
  );

  // Final cycle of an instruction frees the port for back-to-back issue.
  assign last_cycle  = (state_q == StRun && cnt_q == '0 && !ldsw_q) || state_q == StLdswClr;
  assign instr_ready = !flush && (state_q == StIdle || last_cycle);
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ldsw_q    <= 1'b0;
      ctrl_q    <= CtrlNone;
      alu_q     <= '0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ldsw_q    <= 1'b0;
      ctrl_q    <= CtrlNone;
      alu_q     <= '0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      illegal_q <= dec_illegal;
      if (dec_illegal) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        ldsw_q  <= 1'b0;
        ctrl_q  <= CtrlNone;
        alu_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= StRun;
        cnt_q   <= dec_count;
        ldsw_q  <= dec_ldsw;
        ctrl_q  <= dec_ctrl;
        alu_q   <= dec_alu;
        busy_q  <= (dec_count != '0) || dec_ldsw;
      end
    end else begin
      illegal_q <= 1'b0;
      if (state_q == StRun && ldsw_q) begin
        state_q <= StLdswClr;
        ldsw_q  <= 1'b0;
        ctrl_q  <= CtrlLdswClr;
        alu_q   <= '0;
        busy_q  <= 1'b0;
      end else if (state_q == StRun && cnt_q != '0) begin
        // Strobes hold while the repeat count drains; busy drops on the last one.
        cnt_q  <= cnt_q - 1'b1;
        busy_q <= cnt_q != OPERAND_WIDTH'(1);
      end else begin
        state_q <= StIdle;
        cnt_q   <= '0;
        ldsw_q  <= 1'b0;
        ctrl_q  <= CtrlNone;
        alu_q   <= '0;
        busy_q  <= 1'b0;
      end
    end
  end

  assign f_reg_e    = ctrl_q.f_reg_e;
  assign f_wait     = ctrl_q.f_wait;
  assign f_load     = ctrl_q.f_load;
  assign f_clr      = ctrl_q.f_clr;
  assign wr_res     = ctrl_q.wr_res;
  assign alu_reg_en = alu_q;
  assign busy       = busy_q;
  assign illegal    = illegal_q;

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Parametrised, clocked successor to the combinational opcode decoder: accepts instructions over a valid/ready stream, decodes each one, and drives registered control strobes to the datapath. It sits between instruction fetch and the ALU/result-register datapath. Beyond single-cycle decode, it adds:
- repeat counts for MAC;
- timed WAIT;
- a two-phase LDSW;
- an indexed register-enable set generalised to N_REGS registers;
- illegal-opcode reporting.

## Interface
- OPCODE_WIDTH, 3: opcode field width (≥3).
- OPERAND_WIDTH, 8: operand field width; sets the repeat/wait counter width.
- N_REGS, 3: number of ALU operand registers; width of alu_reg_en (≥1, ≤2^OPERAND_WIDTH).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept this cycle.
- instr_opcode  in  OPCODE_WIDTH  opcode.
- instr_operand  in  OPERAND_WIDTH  count or register index.
- flush  in  1  synchronous abort of current instruction.
- f_reg_e, f_wait, f_load, f_clr, wr_res  out  1 each  control strobes.
- alu_reg_en  out  N_REGS  ALU register load enables.
- busy  out  1  a multi-cycle instruction is executing.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
Encodings:
- MOV=0, MAC=1, WAIT=2, SETR=3, LDSW=4.
- 5..2^OPCODE_WIDTH-1 are illegal.

Handshake:
- An instruction is accepted on a rising edge where instr_valid && instr_ready.
- Opcode and operand are sampled only then.

State machine: IDLE, RUN, LDSW_CLR.
- IDLE: instr_ready=1; all strobes 0.
- MOV (RUN, 1 cycle): wr_res=1, f_clr=1, alu_reg_en=all ones.
- MAC n (RUN, n+1 cycles; counter loaded with n, decremented each cycle): f_reg_e=1, wr_res=1, alu_reg_en=0.
- WAIT n (RUN, n+1 cycles): f_wait=1, all else 0.
- SETR i (RUN, 1 cycle): alu_reg_en = one-hot bit i.
  - i ≥ N_REGS is treated as illegal.
- LDSW, 2 cycles:
  - RUN phase: f_load=1, f_reg_e=1, alu_reg_en=all ones.
  - LDSW_CLR phase: f_clr=1, wr_res=1, alu_reg_en=0.
- Illegal opcode/index: accepted, no strobes, illegal=1 for one cycle, then the next instruction proceeds normally.

Ready and busy:
- instr_ready=1 in IDLE, and on the final cycle of any instruction (RUN with counter 0 and not LDSW, or LDSW_CLR). This gives back-to-back issue with no bubble.
- busy=1 in RUN and LDSW_CLR except on the final cycle.

Flush:
- All strobes 0 and state IDLE from the next edge. Highest priority.
- instr_ready=0 while flush=1, so nothing is accepted in the flush cycle.

Counter:
- Unsigned, OPERAND_WIDTH bits, counts down.
- Operand all-ones gives 2^OPERAND_WIDTH cycles; no wrap.

## Timing
- Reset: state IDLE, counter 0. All strobes, alu_reg_en, busy and illegal are 0. instr_ready=1 once rst_n deasserts.
- Asserting rst_n mid-instruction forces the reset values immediately; the instruction is lost.
- Latency: accept at edge k → strobes registered, visible from edge k to edge k+1. MAC/WAIT hold strobes through edge k+n+1.
- Throughput: one single-cycle instruction per clock.
- Outputs are registered; instr_ready is combinational from state and counter only, never from instr_valid.
- Simultaneous final cycle and new accept: the new instruction's strobes follow on the very next cycle with no idle cycle.
- flush together with instr_valid: the instruction is not accepted.

## Structure
- Shared package seq_pkg:
  - opcode_e enum sized by OPCODE_WIDTH;
  - state_e {IDLE, RUN, LDSW_CLR};
  - a decoded-control struct {f_reg_e, f_wait, f_load, f_clr, wr_res, alu_reg_en}.
- One natural sub-module: seq_decode, combinational opcode+operand → control struct, illegal flag and cycle count.
- The sequencer instantiates seq_decode and holds the FSM, counter and output registers.

## Test plan
- Reset, then MOV, SETR 2, SETR 0 issued back-to-back (N_REGS=3) → alu_reg_en 111, 100, 001 on three consecutive cycles; instr_ready stays 1.
- MAC operand 3 → f_reg_e=wr_res=1 for exactly 4 cycles; instr_ready low for the first 3 cycles; a following MOV appears on cycle 5.
- WAIT operand 255 (OPERAND_WIDTH=8) → f_wait high for exactly 256 cycles, busy high for 255 cycles.
- LDSW → cycle 1: f_load=f_reg_e=1, alu_reg_en=111; cycle 2: f_clr=wr_res=1, alu_reg_en=000.
- Opcode 6 and SETR 5 → illegal pulses one cycle each, no strobes; the next MAC 0 executes for exactly 1 cycle.
- flush on cycle 2 of WAIT 10, and rst_n low on cycle 2 of MAC 5 → strobes 0 next edge (flush) or immediately (reset); state returns to IDLE.
